stb_phase_sweep: RTL and testbench

//  Equivalent-time sampler placed directly downstream of the strobe generator in the measure unit.

---
 rtl/stb_phase_sweep.sv | 197 +++++++++++++++++++
 tb/tb_stb_phase_sweep.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_phase_sweep.sv
// rtl/stb_phase_sweep.sv - equivalent-time sampler sweeping a delay across the strobe period.
// Optional watchdog on missing strobes: define STB_PHASE_SWEEP_TIMEOUT_EN.
module stb_phase_sweep #(
   parameter int CNT_WIDTH = 32,
   parameter int ACC_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   input  logic                 stb_i,
   input  logic [CNT_WIDTH-1:0] period_i,
   input  logic                 stb_rdy_i,
   input  logic                 sig_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] step_i,
   input  logic [ACC_WIDTH-1:0] n_avg_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [CNT_WIDTH-1:0] res_delay_o,
   output logic [ACC_WIDTH-1:0] res_hits_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ARM       = 3'd1;
   localparam logic [2:0] S_WAIT_EDGE = 3'd2;
   localparam logic [2:0] S_DELAY     = 3'd3;
   localparam logic [2:0] S_RESULT    = 3'd4;
   localparam logic [2:0] S_NEXT      = 3'd5;

   logic [2:0]           state_q, state_d;
   logic                 sig_s1_q, sig_s1_d, sig_s2_q, sig_s2_d;
   logic                 stb_q, stb_d;
   logic [CNT_WIDTH-1:0] phase_q, phase_d, phase_cur;
   logic [CNT_WIDTH-1:0] period_q, period_d, step_q, step_d, cur_delay_q, cur_delay_d;
   logic [ACC_WIDTH-1:0] n_avg_q, n_avg_d, hits_q, hits_d, scnt_q, scnt_d, scnt_inc;
   logic                 busy_q, busy_d, done_q, done_d, err_q, err_d, res_valid_q, res_valid_d;
   logic                 stb_e, take_sample, wd_trip;
   logic [CNT_WIDTH:0]   nd;
`ifdef STB_PHASE_SWEEP_TIMEOUT_EN
   logic [CNT_WIDTH:0]   wd_q, wd_d, wd_lim;
`endif

   always_comb begin
      state_d     = state_q;
      sig_s1_d    = sig_i;
      sig_s2_d    = sig_s1_q;
      stb_d       = stb_i;
      period_d    = period_q;
      step_d      = step_q;
      n_avg_d     = n_avg_q;
      cur_delay_d = cur_delay_q;
      hits_d      = hits_q;
      scnt_d      = scnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      take_sample = 1'b0;
      wd_trip     = 1'b0;

      // Phase reads 0 in the edge cycle itself, so the count restarts combinationally.
      stb_e     = stb_i & ~stb_q;
      phase_cur = stb_e ? '0 : phase_q;
      phase_d   = phase_cur + CNT_WIDTH'(1);
      nd        = {1'b0, cur_delay_q} + {1'b0, step_q};
      scnt_inc  = scnt_q + ACC_WIDTH'(1);

      case (state_q)
         S_IDLE: begin
            if (start_i && stb_rdy_i) begin
               err_d       = 1'b0;
               busy_d      = 1'b1;
               period_d    = period_i;
               step_d      = (step_i == '0) ? CNT_WIDTH'(1) : step_i;
               n_avg_d     = (n_avg_i == '0) ? ACC_WIDTH'(1) : n_avg_i;
               cur_delay_d = '0;
               state_d     = S_ARM;
            end
         end
         S_ARM: begin
            hits_d  = '0;
            scnt_d  = '0;
            state_d = S_WAIT_EDGE;
         end
         S_WAIT_EDGE: begin
            if (stb_e) begin
               if (cur_delay_q == '0) take_sample = 1'b1;
               else                   state_d     = S_DELAY;
            end
         end
         S_DELAY: begin
            if (phase_cur == cur_delay_q) take_sample = 1'b1;
         end
         S_RESULT: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = S_NEXT;
            end
         end
         S_NEXT: begin
            if (nd >= {1'b0, period_q}) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cur_delay_d = nd[CNT_WIDTH-1:0];
               state_d     = S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_sample) begin
         hits_d = (sig_s2_q && (hits_q != '1)) ? hits_q + ACC_WIDTH'(1) : hits_q;
         scnt_d = scnt_inc;
         if (scnt_inc == n_avg_q) begin
            state_d     = S_RESULT;
            res_valid_d = 1'b1;
         end else begin
            state_d = S_WAIT_EDGE;
         end
      end

`ifdef STB_PHASE_SWEEP_TIMEOUT_EN
      wd_lim = {period_q, 1'b0};
      if (wd_lim < (CNT_WIDTH+1)'(4)) wd_lim = (CNT_WIDTH+1)'(4);
      wd_d = wd_q;
      if (state_q == S_IDLE || stb_e) begin
         wd_d = '0;
      end else if (state_q == S_WAIT_EDGE || state_q == S_DELAY) begin
         wd_d    = wd_q + (CNT_WIDTH+1)'(1);
         wd_trip = (wd_d >= wd_lim);
      end
`endif

      // Abort wins over every other transition, including a result about to be posted.
      if (state_q != S_IDLE && (!stb_rdy_i || wd_trip)) begin
         err_d       = 1'b1;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         res_valid_d = 1'b0;
         state_d     = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q     <= S_IDLE;
         sig_s1_q    <= 1'b0;
         sig_s2_q    <= 1'b0;
         stb_q       <= 1'b0;
         phase_q     <= '0;
         period_q    <= '0;
         step_q      <= '0;
         n_avg_q     <= '0;
         cur_delay_q <= '0;
         hits_q      <= '0;
         scnt_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef STB_PHASE_SWEEP_TIMEOUT_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sig_s1_q    <= sig_s1_d;
         sig_s2_q    <= sig_s2_d;
         stb_q       <= stb_d;
         phase_q     <= phase_d;
         period_q    <= period_d;
         step_q      <= step_d;
         n_avg_q     <= n_avg_d;
         cur_delay_q <= cur_delay_d;
         hits_q      <= hits_d;
         scnt_q      <= scnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
`ifdef STB_PHASE_SWEEP_TIMEOUT_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign res_valid_o = res_valid_q;
   assign res_delay_o = cur_delay_q;
   assign res_hits_o  = hits_q;

endmodule

// File: tb/tb_stb_phase_sweep.sv
// tb/tb_stb_phase_sweep.sv - self-checking bench for stb_phase_sweep.
module tb_stb_phase_sweep;
   localparam int CW = 32;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          arst_i = 1'b1;
   logic          stb_i = 1'b0;
   logic [CW-1:0] period_i = '0;
   logic          stb_rdy_i = 1'b0;
   logic          sig_i = 1'b0;
   logic          start_i = 1'b0;
   logic [CW-1:0] step_i = '0;
   logic [AW-1:0] n_avg_i = '0;
   logic          busy_o, done_o, err_o, res_valid_o;
   logic          res_ready_i = 1'b1;
   logic [CW-1:0] res_delay_o;
   logic [AW-1:0] res_hits_o;

   typedef struct {
      int stb_per;
      int period;
      int step;
      int n_avg;
      int lo;
      int hi;
   } vec_t;

   typedef struct {
      int delay;
      int hits;
   } res_t;

   vec_t vecs[5];
   res_t exp_q[$];
   res_t e_r;
   int   n_vec = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   gen_per = 100;
   int   sig_lo = 0;
   int   sig_hi = 100;
   bit   gen_on = 1'b1;

   stb_phase_sweep #(.CNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
      .clk_i       (clk),
      .arst_i      (arst_i),
      .stb_i       (stb_i),
      .period_i    (period_i),
      .stb_rdy_i   (stb_rdy_i),
      .sig_i       (sig_i),
      .start_i     (start_i),
      .step_i      (step_i),
      .n_avg_i     (n_avg_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_delay_o (res_delay_o),
      .res_hits_o  (res_hits_o)
   );

   initial forever #5 clk = ~clk;

   // Strobe source: one-cycle pulse at phase 0, sig_i high for phases [sig_lo, sig_hi).
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (gen_on) begin
            ph    = (ph + 1 >= gen_per) ? 0 : ph + 1;
            stb_i = (ph == 0);
            sig_i = (ph >= sig_lo) && (ph < sig_hi);
         end else begin
            stb_i = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (done_o) done_cnt++;
      if (res_valid_o && res_ready_i) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got delay %0d hits %0d, required none",
                     res_delay_o, res_hits_o);
         end else begin
            e_r = exp_q.pop_front();
            chk("res_delay", longint'(res_delay_o), e_r.delay);
            chk("res_hits", longint'(res_hits_o), e_r.hits);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_gen(input vec_t v);
      gen_per = v.stb_per;
      sig_lo  = v.lo;
      sig_hi  = v.hi;
      tick(3 * v.stb_per + 5);
   endtask

   // Reference model: sample at delay d sees sig_i from phase d-2 (two-flop synchronizer).
   task automatic push_exp(input vec_t v);
      int st, na, d, ph;
      st = (v.step == 0) ? 1 : v.step;
      na = (v.n_avg == 0) ? 1 : v.n_avg;
      d  = 0;
      do begin
         ph = (d + v.stb_per - 2) % v.stb_per;
         exp_q.push_back('{d, ((ph >= v.lo) && (ph < v.hi)) ? na : 0});
         d += st;
      end while (d < v.period);
   endtask

   task automatic do_start(input vec_t v);
      period_i = CW'(v.period);
      step_i   = CW'(v.step);
      n_avg_i  = AW'(v.n_avg);
      start_i  = 1'b1;
      tick(1);
      start_i  = 1'b0;
      @(negedge clk);
      chk("busy_after_start", longint'(busy_o), 1);
      chk("err_after_start", longint'(err_o), 0);
   endtask

   task automatic finish_sweep();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         if (done_o) begin
            got = 1'b1;
            break;
         end
      end
      chk("done_seen", longint'(got), 1);
      tick(5);
      chk("done_pulse_count", done_cnt, 1);
      chk("busy_after_done", longint'(busy_o), 0);
      chk("err_after_done", longint'(err_o), 0);
      chk("results_outstanding", exp_q.size(), 0);
   endtask

   task automatic run_vec(input vec_t v);
      res_ready_i = 1'b1;
      set_gen(v);
      done_cnt = 0;
      push_exp(v);
      do_start(v);
      finish_sweep();
   endtask

   task automatic wait_valid(input string name);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (res_valid_o) begin
            got = 1'b1;
            break;
         end
      end
      chk(name, longint'(got), 1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, longint'(busy_o), 0);
      chk({tag, "_done"}, longint'(done_o), 0);
      chk({tag, "_err"}, longint'(err_o), 0);
      chk({tag, "_valid"}, longint'(res_valid_o), 0);
      chk({tag, "_delay"}, longint'(res_delay_o), 0);
      chk({tag, "_hits"}, longint'(res_hits_o), 0);
   endtask

   initial begin
      vec_t v;
      bit   stable, got;
      vecs[0] = '{100, 100, 10, 4, 0, 100};
      vecs[1] = '{100, 100, 10, 4, 20, 60};
      vecs[2] = '{3, 3, 0, 0, 0, 3};
      vecs[3] = '{100, 0, 10, 2, 0, 100};
      vecs[4] = '{50, 50, 7, 3, 10, 30};

      tick(3);
      chk_outputs_zero("reset");
      stb_rdy_i = 1'b1;
      arst_i    = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Result held off by res_ready_i: outputs frozen, sweep resumes at delay 10.
      set_gen(vecs[0]);
      done_cnt = 0;
      push_exp(vecs[0]);
      res_ready_i = 1'b0;
      do_start(vecs[0]);
      wait_valid("hold_valid_seen");
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (!res_valid_o || res_delay_o != 0 || res_hits_o != 4) stable = 1'b0;
      end
      chk("hold_stable", longint'(stable), 1);
      @(posedge clk);
      #1;
      res_ready_i = 1'b1;
      finish_sweep();

      // stb_rdy_i drop while a result is pending.
      done_cnt = 0;
      res_ready_i = 1'b0;
      do_start(vecs[0]);
      wait_valid("abort_valid_seen");
      tick(10);
      stb_rdy_i = 1'b0;
      tick(1);
      @(negedge clk);
      chk("abort_err", longint'(err_o), 1);
      chk("abort_busy", longint'(busy_o), 0);
      chk("abort_valid", longint'(res_valid_o), 0);
      stb_rdy_i   = 1'b1;
      res_ready_i = 1'b1;
      tick(300);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_err_sticky", longint'(err_o), 1);
      run_vec(vecs[3]);

      // Asynchronous reset in the middle of a DELAY wait.
      v = '{100, 100, 50, 1, 0, 100};
      set_gen(v);
      done_cnt = 0;
      exp_q.push_back('{0, 1});
      do_start(v);
      got = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            got = 1'b1;
            break;
         end
      end
      chk("pre_reset_result", longint'(got), 1);
      for (int k = 0; k < 200 && !stb_i; k++) @(negedge clk);
      tick(20);
      arst_i = 1'b1;
      #2;
      chk_outputs_zero("midreset");
      tick(2);
      arst_i = 1'b0;
      tick(300);
      chk("midreset_no_done", done_cnt, 0);
      chk("midreset_busy", longint'(busy_o), 0);

`ifdef STB_PHASE_SWEEP_TIMEOUT_EN
      gen_on = 1'b0;
      done_cnt = 0;
      tick(5);
      do_start(vecs[0]);
      tick(190);
      chk("wd_not_early", longint'(err_o), 0);
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (err_o) begin
            got = 1'b1;
            break;
         end
      end
      chk("wd_err", longint'(got), 1);
      chk("wd_busy", longint'(busy_o), 0);
      chk("wd_no_done", done_cnt, 0);
      gen_on = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
